// File: rtl/synth_ctrl_pkg.sv
// Shared definitions for the synth control blocks: loader state encoding
// and default program RAM geometry.
package synth_ctrl_pkg;

    localparam int         LDR_ADDR_W    = 10;
    localparam int         LDR_INSTR_W   = 18;
    localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_B0,
        LD_B1,
        LD_B2,
        LD_WRITE,
        LD_CSUM,
        LD_RELEASE,
        LD_ERR
    } ld_state_t;

endpackage

// File: rtl/prog_ram_loader_byte_timeout.sv
// byte_timeout: idle-cycle watchdog for byte streams; counts enabled,
// uncleared cycles and flags expiry after LIMIT of them.
module byte_timeout #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;
    logic         w_at_limit;

    assign w_at_limit = (r_cnt == W'(LIMIT - 1));
    assign o_expire   = i_en && !i_clr && w_at_limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_ram_loader.sv
// PicoBlaze program RAM reloader: parses SYNC/count/payload frames into
// 18-bit words. Optional trailing checksum: PROG_RAM_LOADER_CHECKSUM_EN.
module prog_ram_loader
    import synth_ctrl_pkg::*;
#(
    parameter int         ADDR_W      = LDR_ADDR_W,
    parameter int         INSTR_W     = LDR_INSTR_W,
    parameter logic [7:0] SYNC_BYTE   = LDR_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         RST_HOLD    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [INSTR_W-1:0] ram_wdata,
    output logic               ram_we,
    output logic               proc_reset,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    localparam int          HOLD_W    = $clog2(RST_HOLD + 1);
    localparam int          HI_W      = INSTR_W - 16;
    localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_W);

    ld_state_t r_state;
    ld_state_t w_next;

    logic [2:0]        r_cnt_hi;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_b0;
    logic [7:0]        r_b1;
    logic [7:0]        r_b2;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [HOLD_W-1:0] r_hold;
    logic              r_proc_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic        w_xfer;
    logic        w_sync;
    logic        w_tmo_en;
    logic        w_tmo_exp;
    logic [31:0] w_count;
    logic        w_count_bad;
    logic        w_last;
    logic        w_hold_end;

    assign rx_ready = !(r_state == LD_WRITE || r_state == LD_RELEASE);
    assign w_xfer   = rx_valid && rx_ready;
    assign w_sync   = w_xfer && (rx_data == SYNC_BYTE) &&
                      (r_state == LD_IDLE || r_state == LD_ERR);

    assign w_count     = {21'd0, r_cnt_hi, rx_data};
    assign w_count_bad = (w_count == 32'd0) || (w_count > MAX_WORDS);
    assign w_last      = ((r_words + 1'b1) == r_count);
    assign w_hold_end  = (r_hold == HOLD_W'(RST_HOLD - 1));

    assign w_tmo_en = (r_state == LD_CNT_HI) || (r_state == LD_CNT_LO) ||
                      (r_state == LD_B0) || (r_state == LD_B1) ||
                      (r_state == LD_B2) || (r_state == LD_CSUM);

    byte_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_xfer),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_exp)
    );

`ifdef PROG_RAM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_chk;

    assign w_sum_chk = r_sum + rx_data;

    // SYNC is excluded; everything after it folds into the running sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_sync) begin
            r_sum <= '0;
        end else if (w_xfer && w_tmo_en) begin
            r_sum <= w_sum_chk;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LD_IDLE, LD_ERR: begin
                if (w_sync) begin
                    w_next = LD_CNT_HI;
                end else begin
                    w_next = LD_IDLE;
                end
            end
            LD_CNT_HI: begin
                if (w_xfer)         w_next = LD_CNT_LO;
                else if (w_tmo_exp) w_next = LD_ERR;
            end
            LD_CNT_LO: begin
                if (w_xfer)         w_next = w_count_bad ? LD_ERR : LD_B0;
                else if (w_tmo_exp) w_next = LD_ERR;
            end
            LD_B0: begin
                if (w_xfer)         w_next = LD_B1;
                else if (w_tmo_exp) w_next = LD_ERR;
            end
            LD_B1: begin
                if (w_xfer)         w_next = LD_B2;
                else if (w_tmo_exp) w_next = LD_ERR;
            end
            LD_B2: begin
                if (w_xfer)         w_next = LD_WRITE;
                else if (w_tmo_exp) w_next = LD_ERR;
            end
            LD_WRITE: begin
                if (!w_last) begin
                    w_next = LD_B0;
                end else begin
`ifdef PROG_RAM_LOADER_CHECKSUM_EN
                    w_next = LD_CSUM;
`else
                    w_next = LD_RELEASE;
`endif
                end
            end
`ifdef PROG_RAM_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (w_xfer) begin
                    w_next = (w_sum_chk == 8'h00) ? LD_RELEASE : LD_ERR;
                end else if (w_tmo_exp) begin
                    w_next = LD_ERR;
                end
            end
`endif
            LD_RELEASE: begin
                if (w_hold_end) w_next = LD_IDLE;
            end
            default: w_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_hi <= '0;
            r_count  <= '0;
            r_b0     <= '0;
            r_b1     <= '0;
            r_b2     <= '0;
        end else if (w_xfer) begin
            unique case (r_state)
                LD_CNT_HI: r_cnt_hi <= rx_data[2:0];
                LD_CNT_LO: r_count  <= w_count[ADDR_W:0];
                LD_B0:     r_b0     <= rx_data;
                LD_B1:     r_b1     <= rx_data;
                LD_B2:     r_b2     <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_words <= '0;
        end else if (w_sync) begin
            r_addr  <= '0;
            r_words <= '0;
        end else if (r_state == LD_WRITE) begin
            r_addr  <= r_addr + 1'b1;
            r_words <= r_words + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_state == LD_RELEASE) begin
            r_hold <= r_hold + 1'b1;
        end else begin
            r_hold <= '0;
        end
    end

    // proc_reset stays high on any abort: a half-written image must not run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proc_reset <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_sync) begin
                r_proc_reset <= 1'b1;
                r_busy       <= 1'b1;
                r_error      <= 1'b0;
            end else if (w_next == LD_ERR) begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
            end else if (r_state == LD_RELEASE && w_hold_end) begin
                r_proc_reset <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
            end
        end
    end

    assign ram_we       = (r_state == LD_WRITE);
    assign ram_addr     = r_addr;
    assign ram_wdata    = {r_b0[HI_W-1:0], r_b1, r_b2};
    assign proc_reset   = r_proc_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
